bpu_btb_ras: RTL and testbench



---
 rtl/bpu_btb_ras.sv | 134 +++++++++++++
 tb/tb_bpu_btb_ras.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bpu_btb_ras.sv
// Branch predictor: direct-mapped tagged BTB with saturating direction
// counters, plus a circular return-address stack for JALR returns.
// Lookup is combinational from the fetch pc; updates arrive from EX,
// one resolved control-flow instruction per cycle.
module bpu_btb_ras #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              _pc,
  output logic                           prediction,
  input  logic                           br_update,
  input  logic                           br,
  input  logic                           br_JALR,
  input  logic                           br_call,
  input  logic                           br_ret,
  input  logic [ADDR_W-1:0]              br_address,
  input  logic [ADDR_W-1:0]              br_pc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam int PTR_W   = $clog2(RAS_DEPTH);
  localparam int RC_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic              tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]  tbl_tag    [ENTRIES];
  logic [ADDR_W-1:0] tbl_target [ENTRIES];
  logic [CNT_W-1:0]  tbl_cnt    [ENTRIES];
  logic              tbl_is_ret [ENTRIES];

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;   // next free slot; top of stack is ras_ptr-1
  logic [PTR_W-1:0]  ras_top_ptr;

  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              l_hit, u_hit;
  logic [ADDR_W-1:0] link_addr;
  logic              unused_bits;

  assign l_idx       = pc[IDX_W+1:2];
  assign l_tag       = pc[ADDR_W-1:IDX_W+2];
  assign u_idx       = br_pc[IDX_W+1:2];
  assign u_tag       = br_pc[ADDR_W-1:IDX_W+2];
  assign l_hit       = tbl_valid[l_idx] && (tbl_tag[l_idx] == l_tag);
  assign u_hit       = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
  assign link_addr   = br_pc + ADDR_W'(4);
  assign ras_top_ptr = ras_ptr - PTR_W'(1);
  assign unused_bits = ^{pc[1:0], br_pc[1:0]};

  // Combinational prediction from pre-edge table/RAS state (no bypass).
  always_comb begin
    _pc        = pc + ADDR_W'(4);
    prediction = 1'b0;
    if (rst) begin
      _pc = '0;
    end else if (l_hit && tbl_is_ret[l_idx]) begin
      if (ras_count != '0) begin
        _pc        = ras_mem[ras_top_ptr];
        prediction = 1'b1;
      end
    end else if (l_hit && tbl_cnt[l_idx][CNT_W-1]) begin
      _pc        = tbl_target[l_idx];
      prediction = 1'b1;
    end
  end

  // BTB training from the resolved EX instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_cnt[i]    <= '0;
        tbl_is_ret[i] <= 1'b0;
      end
    end else if (br_update) begin
      if (!br_JALR) begin
        if (u_hit) begin
          if (br) begin
            if (tbl_cnt[u_idx] != CNT_MAX) tbl_cnt[u_idx] <= tbl_cnt[u_idx] + CNT_W'(1);
            tbl_target[u_idx] <= br_address;
          end else if (tbl_cnt[u_idx] != '0) begin
            tbl_cnt[u_idx] <= tbl_cnt[u_idx] - CNT_W'(1);
          end
        end else if (br) begin
          tbl_valid[u_idx]  <= 1'b1;
          tbl_tag[u_idx]    <= u_tag;
          tbl_target[u_idx] <= br_address;
          tbl_cnt[u_idx]    <= CNT_WEAK;
          tbl_is_ret[u_idx] <= 1'b0;
        end
      end else if (br_ret) begin
        tbl_valid[u_idx]  <= 1'b1;
        tbl_tag[u_idx]    <= u_tag;
        tbl_target[u_idx] <= br_address;
        tbl_cnt[u_idx]    <= CNT_MAX;
        tbl_is_ret[u_idx] <= 1'b1;
      end else if (u_hit) begin
        // Indirect non-return jump: drop the stale prediction for this pc.
        tbl_valid[u_idx] <= 1'b0;
      end
    end
  end

  // Return-address stack: push on call, pop on return, replace top on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (br_update) begin
      if (br_call && !br_ret) begin
        ras_mem[ras_ptr] <= link_addr;
        ras_ptr          <= ras_ptr + PTR_W'(1);
        if (ras_count != RC_W'(RAS_DEPTH)) ras_count <= ras_count + RC_W'(1);
      end else if (br_ret && !br_call) begin
        if (ras_count != '0) begin
          ras_ptr   <= ras_top_ptr;
          ras_count <= ras_count - RC_W'(1);
        end
      end else if (br_call && br_ret) begin
        ras_mem[ras_top_ptr] <= link_addr;
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Directed bench for bpu_btb_ras: stimulus pushes expected lookup results
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_bpu_btb_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        prediction;
  logic        br_update, br, br_JALR, br_call, br_ret;
  logic [31:0] br_address, br_pc;
  logic [2:0]  ras_count;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [2:0]  cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  bpu_btb_ras #(.ADDR_W(32), .IDX_W(8), .CNT_W(2), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), ._pc(npc), .prediction(prediction),
    .br_update(br_update), .br(br), .br_JALR(br_JALR), .br_call(br_call),
    .br_ret(br_ret), .br_address(br_address), .br_pc(br_pc), .ras_count(ras_count)
  );

  // Monitor: compare DUT lookup outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: DUT output presented but no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (npc !== e.pc || prediction !== e.pred || ras_count !== e.cnt) begin
          fails++;
          $display("FAIL %s: got _pc=%h pred=%b ras_count=%0d, want _pc=%h pred=%b ras_count=%0d",
                   e.name, npc, prediction, ras_count, e.pc, e.pred, e.cnt);
        end
      end
    end
  end

  // One clock of stimulus: optional lookup check plus optional EX update.
  task automatic cyc(input logic r, input logic [31:0] p, input logic chk,
                     input logic [31:0] epc, input logic ep, input logic [2:0] ec,
                     input string nm, input logic u, input logic b, input logic j,
                     input logic c, input logic rt, input logic [31:0] ba,
                     input logic [31:0] bp);
    exp_t e;
    @(posedge clk); #1;
    rst = r; pc = p;
    br_update = u; br = b; br_JALR = j; br_call = c; br_ret = rt;
    br_address = ba; br_pc = bp;
    chk_en = chk;
    if (chk) begin
      e.pc = epc; e.pred = ep; e.cnt = ec; e.name = nm;
      exp_q.push_back(e);
    end
  endtask

  task automatic look(input logic [31:0] p, input logic [31:0] epc, input logic ep,
                      input logic [2:0] ec, input string nm);
    cyc(1'b0, p, 1'b1, epc, ep, ec, nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic upd(input logic b, input logic j, input logic c, input logic rt,
                     input logic [31:0] ba, input logic [31:0] bp);
    cyc(1'b0, 32'hF000, 1'b0, 32'h0, 1'b0, 3'd0, "", 1'b1, b, j, c, rt, ba, bp);
  endtask

  initial begin
    rst = 1'b1; pc = 32'h100;
    br_update = 1'b0; br = 1'b0; br_JALR = 1'b0; br_call = 1'b0; br_ret = 1'b0;
    br_address = 32'h0; br_pc = 32'h0;

    // Reset
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 3'd0, "", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 32'h100, 1'b1, 32'h0, 1'b0, 3'd0, "reset_out", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look(32'h100, 32'h104, 1'b0, 3'd0, "post_reset");

    // Allocation and counter hysteresis at 0x40
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // cnt=10
    look(32'h40, 32'h80, 1'b1, 3'd0, "alloc_weak_taken");
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // cnt=01
    look(32'h40, 32'h44, 1'b0, 3'd0, "one_not_taken");
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 10
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 11
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 11 saturated
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 10
    look(32'h40, 32'h80, 1'b1, 3'd0, "sat_high_no_wrap");
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 01
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 00
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 00 saturated
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);            // 01
    look(32'h40, 32'h44, 1'b0, 3'd0, "sat_low_no_wrap");
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h90, 32'h40);            // 10, target 0x90
    look(32'h40, 32'h90, 1'b1, 3'd0, "taken_updates_target");
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h90, 32'h40);            // 11
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'hAA0, 32'h40);           // 10, target kept
    look(32'h40, 32'h90, 1'b1, 3'd0, "not_taken_keeps_target");

    // Tag aliasing on index 0x10
    look(32'h440, 32'h444, 1'b0, 3'd0, "alias_miss");
    upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h440);
    look(32'h440, 32'h500, 1'b1, 3'd0, "alias_alloc");
    look(32'h40, 32'h44, 1'b0, 3'd0, "alias_evicted");
    upd(1'b0, 1'b0, 1'b0, 1'b0, 32'h900, 32'h800);
    look(32'h800, 32'h804, 1'b0, 3'd0, "nt_miss_no_alloc");
    upd(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h440);          // JALR non-return kills
    look(32'h440, 32'h444, 1'b0, 3'd0, "jalr_kill");

    // RAS call/return
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h204, 32'h300);          // ret on empty RAS
    look(32'h300, 32'h304, 1'b0, 3'd0, "ret_empty_ras");
    upd(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h200);         // call at 0x200
    look(32'h300, 32'h204, 1'b1, 3'd1, "ras_return_predict");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h204, 32'h300);          // pop
    look(32'h300, 32'h304, 1'b0, 3'd0, "ras_after_pop");

    // RAS overflow
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h10);
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h20);
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h30);
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h40);
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h50);
    look(32'h300, 32'h54, 1'b1, 3'd4, "ras_full_top");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h54, 32'h300);
    look(32'h300, 32'h44, 1'b1, 3'd3, "ras_pop1");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h300);
    look(32'h300, 32'h34, 1'b1, 3'd2, "ras_pop2");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h34, 32'h300);
    look(32'h300, 32'h24, 1'b1, 3'd1, "ras_pop3");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h300);
    look(32'h300, 32'h304, 1'b0, 3'd0, "ras_pop4_empty");
    upd(1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h300);
    look(32'h300, 32'h304, 1'b0, 3'd0, "ras_pop5_noop");

    // Same-cycle lookup and first taken update at 0x40 (killed earlier)
    cyc(1'b0, 32'h40, 1'b1, 32'h44, 1'b0, 3'd0, "same_cycle_no_bypass",
        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h40);
    look(32'h40, 32'h80, 1'b1, 3'd0, "same_cycle_next");

    // Call+return on the same instruction replaces top only
    upd(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h10);          // top 0x14, count 1
    upd(1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h60);
    look(32'h60, 32'h64, 1'b1, 3'd1, "call_ret_replace_top");
    cyc(1'b0, 32'h60, 1'b1, 32'h64, 1'b1, 3'd1, "no_update_ignored",
        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000, 32'h70);
    look(32'h60, 32'h64, 1'b1, 3'd1, "no_update_after");

    // Reset during an update discards it
    cyc(1'b1, 32'h60, 1'b1, 32'h0, 1'b0, 3'd1, "reset_mid_update",
        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000, 32'h60);
    look(32'h60, 32'h64, 1'b0, 3'd0, "after_reset_cleared");

    @(posedge clk); #1;
    chk_en = 1'b0;
    br_update = 1'b0;
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
